// File: rtl/botones_antirebote_pkg.sv
// Shared constants and helpers for the push-button conditioning block.
package botones_antirebote_pkg;

    localparam int unsigned DEBOUNCE_CYCLES  = 16;
    localparam int unsigned TEST_HOLD_CYCLES = 64;
    localparam int unsigned CNT_W            = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/botones_antirebote_debounce_filter.sv
// Two-flop synchroniser followed by a stable-count debounce filter.
// Flops hold the value XOR INIT so that an all-zero power-up equals INIT.
module botones_antirebote_debounce_filter
    import botones_antirebote_pkg::*;
#(
    parameter int unsigned CYCLES = DEBOUNCE_CYCLES,
    parameter logic        INIT   = 1'b0
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_raw,
    output logic o_level_c
);

    logic [1:0]       r_sync;
    logic             r_lvl;
    logic [CNT_W-1:0] r_cnt;
    logic             w_lvl_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Count consecutive samples that disagree with the level; adopt after CYCLES.
    always_comb begin
        w_lvl_nxt = r_lvl;
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_lvl_nxt = 1'b0;
            w_cnt_nxt = '0;
        end else if (r_sync[1] == r_lvl) begin
            w_cnt_nxt = '0;
        end else if (r_cnt >= CNT_W'(CYCLES - 1)) begin
            w_lvl_nxt = r_sync[1];
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = sat_inc(r_cnt);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_raw ^ INIT};
        end
        r_lvl <= w_lvl_nxt;
        r_cnt <= w_cnt_nxt;
    end

    // Level as it will be after this edge, so consumers can register it without extra delay.
    assign o_level_c = w_lvl_nxt ^ INIT;

endmodule

// File: rtl/botones_antirebote.sv
// Conditions the four console push-buttons into clean levels and pulses for the main FSM.
module botones_antirebote
    import botones_antirebote_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES = TEST_HOLD_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic test,
    input  logic b_energia,
    input  logic b_medicina,
    output logic Senal_Test,
    output logic Senal_Energia,
    output logic Senal_Medicina,
    output logic Senal_Reset
);

    logic             w_clr;
    logic             w_test_lvl;
    logic             w_en_lvl;
    logic             w_med_lvl;
    logic             w_rst_lvl;
    logic [1:0]       r_edge;
    logic [CNT_W-1:0] r_hold;
    logic             r_test;
    logic             r_en;
    logic             r_med;
    logic             r_rst;

    assign w_clr = ~reset;

    botones_antirebote_debounce_filter #(.CYCLES(DEB_CYCLES), .INIT(1'b0)) u_deb_test (
        .i_clk     (clk),
        .i_clr     (w_clr),
        .i_raw     (test),
        .o_level_c (w_test_lvl)
    );

    botones_antirebote_debounce_filter #(.CYCLES(DEB_CYCLES), .INIT(1'b0)) u_deb_energia (
        .i_clk     (clk),
        .i_clr     (w_clr),
        .i_raw     (b_energia),
        .o_level_c (w_en_lvl)
    );

    botones_antirebote_debounce_filter #(.CYCLES(DEB_CYCLES), .INIT(1'b0)) u_deb_medicina (
        .i_clk     (clk),
        .i_clr     (w_clr),
        .i_raw     (b_medicina),
        .o_level_c (w_med_lvl)
    );

    // The reset button's own filter must keep running while reset is held.
    botones_antirebote_debounce_filter #(.CYCLES(DEB_CYCLES), .INIT(1'b1)) u_deb_reset (
        .i_clk     (clk),
        .i_clr     (1'b0),
        .i_raw     (reset),
        .o_level_c (w_rst_lvl)
    );

    // Edge detectors for the pulse buttons and the long-press qualifier for test.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_edge <= 2'b00;
            r_hold <= '0;
            r_test <= 1'b0;
            r_en   <= 1'b0;
            r_med  <= 1'b0;
        end else begin
            r_edge <= {w_med_lvl, w_en_lvl};
            r_en   <= w_en_lvl & ~r_edge[0];
            r_med  <= w_med_lvl & ~r_edge[1];
            if (w_test_lvl) begin
                if (r_hold < CNT_W'(HOLD_CYCLES)) begin
                    r_hold <= sat_inc(r_hold);
                end
                r_test <= (r_hold >= CNT_W'(HOLD_CYCLES));
            end else begin
                r_hold <= '0;
                r_test <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_rst <= ~w_rst_lvl;
    end

    assign Senal_Test     = r_test;
    assign Senal_Energia  = r_en;
    assign Senal_Medicina = r_med;
    assign Senal_Reset    = r_rst;

endmodule

// File: tb/tb_botones_antirebote.sv
// Directed and randomized bench for botones_antirebote against a per-cycle reference model.
module tb_botones_antirebote;
    import botones_antirebote_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, test, b_energia, b_medicina;
    logic Senal_Test, Senal_Energia, Senal_Medicina, Senal_Reset;

    botones_antirebote dut (
        .clk            (clk),
        .reset          (reset),
        .test           (test),
        .b_energia      (b_energia),
        .b_medicina     (b_medicina),
        .Senal_Test     (Senal_Test),
        .Senal_Energia  (Senal_Energia),
        .Senal_Medicina (Senal_Medicina),
        .Senal_Reset    (Senal_Reset)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: channel 0 test, 1 energy, 2 medicine, 3 reset button.
    logic dly0 [4];
    logic dly1 [4];
    logic lvl  [4];
    int   run  [4];
    int   hc;
    logic prev_en, prev_med;
    logic e_test, e_en, e_med, e_rst;
    int   n_en, n_med;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic raw [4];
        raw[0] = test; raw[1] = b_energia; raw[2] = b_medicina; raw[3] = reset;
        for (int c = 0; c < 4; c++) begin
            if (c != 3 && !reset) begin
                dly0[c] = 1'b0; dly1[c] = 1'b0; lvl[c] = 1'b0; run[c] = 0;
            end else begin
                if (dly1[c] != lvl[c]) begin
                    run[c]++;
                    if (run[c] == int'(DEBOUNCE_CYCLES)) begin
                        lvl[c] = dly1[c];
                        run[c] = 0;
                    end
                end else begin
                    run[c] = 0;
                end
                dly1[c] = dly0[c];
                dly0[c] = raw[c];
            end
        end
        if (!reset) begin
            hc = 0; e_test = 1'b0; e_en = 1'b0; e_med = 1'b0;
            prev_en = 1'b0; prev_med = 1'b0;
        end else begin
            hc     = lvl[0] ? hc + 1 : 0;
            e_test = (hc >= int'(TEST_HOLD_CYCLES) + 1);
            e_en   = lvl[1] && !prev_en;
            e_med  = lvl[2] && !prev_med;
            prev_en  = lvl[1];
            prev_med = lvl[2];
        end
        e_rst = !lvl[3];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("Senal_Test",     Senal_Test,     e_test);
        chk("Senal_Energia",  Senal_Energia,  e_en);
        chk("Senal_Medicina", Senal_Medicina, e_med);
        chk("Senal_Reset",    Senal_Reset,    e_rst);
        n_en  += int'(Senal_Energia);
        n_med += int'(Senal_Medicina);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic get_out(input int sel);
        case (sel)
            0:       return Senal_Test;
            1:       return Senal_Energia;
            2:       return Senal_Medicina;
            default: return Senal_Reset;
        endcase
    endfunction

    // Count cycles until an output reaches a value; a timeout shows up as a wrong count.
    task automatic wait_lvl(input int sel, input logic val, input int exp_n, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (get_out(sel) !== val && n < 200);
        chk_int(tag, n, exp_n);
    endtask

    initial begin
        reset = 1'b0; test = 1'b0; b_energia = 1'b0; b_medicina = 1'b0;
        for (int c = 0; c < 4; c++) begin
            dly0[c] = (c == 3); dly1[c] = (c == 3); lvl[c] = (c == 3); run[c] = 0;
        end
        hc = 0; prev_en = 1'b0; prev_med = 1'b0;
        e_test = 1'b0; e_en = 1'b0; e_med = 1'b0; e_rst = 1'b0;
        n_en = 0; n_med = 0;

        // Reset held low for 40 cycles.
        wait_lvl(3, 1'b1, 18, "rst_rise_latency");
        ticks(22);
        reset = 1'b1;
        wait_lvl(3, 1'b0, 18, "rst_fall_latency");
        ticks(20);

        // Clean energy press.
        n_en = 0; n_med = 0;
        b_energia = 1'b1;
        wait_lvl(1, 1'b1, 18, "en_pulse_latency");
        ticks(12);
        b_energia = 1'b0;
        ticks(30);
        chk_int("en_pulse_count", n_en, 1);
        chk_int("med_idle_count", n_med, 0);

        // Bouncing at period 20 must never pass the filter.
        n_en = 0; n_med = 0;
        for (int i = 0; i < 200; i++) begin
            b_energia  = ~b_energia;
            b_medicina = ~b_medicina;
            ticks(10);
        end
        b_energia = 1'b0; b_medicina = 1'b0;
        ticks(30);
        chk_int("bounce_en_count", n_en, 0);
        chk_int("bounce_med_count", n_med, 0);

        // Long press on test.
        test = 1'b1;
        wait_lvl(0, 1'b1, 82, "test_rise_latency");
        ticks(175 - 82);
        test = 1'b0;
        wait_lvl(0, 1'b0, 18, "test_fall_latency");
        ticks(20);

        // Medicine held across a reset pulse.
        b_medicina = 1'b1;
        ticks(40);
        n_med = 0;
        reset = 1'b0;
        ticks(20);
        chk_int("med_during_reset", n_med, 0);
        reset = 1'b1;
        wait_lvl(2, 1'b1, 18, "med_requalify_latency");
        b_medicina = 1'b0;
        ticks(40);

        // Simultaneous energy and medicine presses.
        b_energia = 1'b1; b_medicina = 1'b1;
        wait_lvl(1, 1'b1, 18, "sim_en_latency");
        chk("sim_med_same_cycle", Senal_Medicina, 1'b1);
        tick();
        chk("sim_en_one_wide", Senal_Energia, 1'b0);
        chk("sim_med_one_wide", Senal_Medicina, 1'b0);
        b_energia = 1'b0; b_medicina = 1'b0;
        ticks(30);

        // Randomized activity checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) test       = ~test;
            if ($urandom_range(0, 14) == 0) b_energia  = ~b_energia;
            if ($urandom_range(0, 14) == 0) b_medicina = ~b_medicina;
            if ($urandom_range(0, 199) == 0) reset     = ~reset;
            if (i < 1500 && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0) b_energia = ~b_energia;
            end
            tick();
        end
        reset = 1'b1; test = 1'b0; b_energia = 1'b0; b_medicina = 1'b0;
        ticks(120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
